// File: rtl/bus_rw_control.sv
// Read/write strobe sequencer for the data bus buffer and internal register file.
// Optional BUS_RW_CONTROL_SYNC_EN adds 2-flop input synchronizers (+2 cycles latency).
module bus_rw_control #(
  parameter int ADDR_W      = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   CS_n,
  input  logic                   RD_n,
  input  logic                   WR_n,
  input  logic [ADDR_W-1:0]      A,
  output logic                   Internal_RD_WR,
  output logic                   RD_WR,
  output logic [2**ADDR_W-1:0]   reg_sel,
  output logic                   reg_we,
  output logic                   reg_oe,
  output logic                   busy,
  output logic                   err
);

  localparam int SEL_W  = 2**ADDR_W;
  localparam int HOLD_W = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_CAP  = 3'd1;
  localparam logic [2:0] S_WR_DRV  = 3'd2;
  localparam logic [2:0] S_RD_CAP  = 3'd3;
  localparam logic [2:0] S_RD_DRV  = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  logic              cs_n_s;
  logic              rd_n_s;
  logic              wr_n_s;
  logic [ADDR_W-1:0] a_s;
  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              conflict_s;
  logic              start_s;
  logic              hold_done_s;
  logic [1:0]        bus_enc_s;

  function automatic logic [SEL_W-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
    return {{(SEL_W-1){1'b0}}, 1'b1} << addr;
  endfunction

  // (Internal_RD_WR, RD_WR) encoding for each state
  function automatic logic [1:0] bus_enc(input logic [2:0] st);
    logic [1:0] enc;
    case (st)
      S_WR_CAP: enc = 2'b11;
      S_WR_DRV: enc = 2'b10;
      S_RD_DRV: enc = 2'b11;
      default:  enc = 2'b01;
    endcase
    return enc;
  endfunction

`ifdef BUS_RW_CONTROL_SYNC_EN
  logic [1:0]        cs_n_sync_r;
  logic [1:0]        rd_n_sync_r;
  logic [1:0]        wr_n_sync_r;
  logic [ADDR_W-1:0] a_meta_r;
  logic [ADDR_W-1:0] a_sync_r;

  // Two-flop synchronizers; strobes idle high out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n_sync_r <= 2'b11;
      rd_n_sync_r <= 2'b11;
      wr_n_sync_r <= 2'b11;
      a_meta_r    <= '0;
      a_sync_r    <= '0;
    end else begin
      cs_n_sync_r <= {cs_n_sync_r[0], CS_n};
      rd_n_sync_r <= {rd_n_sync_r[0], RD_n};
      wr_n_sync_r <= {wr_n_sync_r[0], WR_n};
      a_meta_r    <= A;
      a_sync_r    <= a_meta_r;
    end
  end

  assign cs_n_s = cs_n_sync_r[1];
  assign rd_n_s = rd_n_sync_r[1];
  assign wr_n_s = wr_n_sync_r[1];
  assign a_s    = a_sync_r;
`else
  assign cs_n_s = CS_n;
  assign rd_n_s = RD_n;
  assign wr_n_s = WR_n;
  assign a_s    = A;
`endif

  assign conflict_s  = (cs_n_s == 1'b0) && (rd_n_s == 1'b0) && (wr_n_s == 1'b0);
  assign start_s     = (cs_n_s == 1'b0) && (rd_n_s != wr_n_s);
  // The counter reaches zero on this edge, so release may now be honoured
  assign hold_done_s = (hold_cnt_r <= 4'd1);
  assign bus_enc_s   = bus_enc(state_nxt_s);

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (conflict_s)   state_nxt_s = S_ERR;
        else if (start_s) state_nxt_s = wr_n_s ? S_RD_CAP : S_WR_CAP;
        else              state_nxt_s = S_IDLE;
      end
      S_WR_CAP: begin
        if (conflict_s) state_nxt_s = S_ERR;
        else            state_nxt_s = S_WR_DRV;
      end
      S_WR_DRV: begin
        if (conflict_s)                                  state_nxt_s = S_ERR;
        else if (hold_done_s && (wr_n_s || cs_n_s))      state_nxt_s = S_RECOVER;
        else                                             state_nxt_s = S_WR_DRV;
      end
      S_RD_CAP: begin
        if (conflict_s) state_nxt_s = S_ERR;
        else            state_nxt_s = S_RD_DRV;
      end
      S_RD_DRV: begin
        if (conflict_s)                                  state_nxt_s = S_ERR;
        else if (hold_done_s && (rd_n_s || cs_n_s))      state_nxt_s = S_RECOVER;
        else                                             state_nxt_s = S_RD_DRV;
      end
      S_RECOVER: begin
        if (conflict_s) state_nxt_s = S_ERR;
        else            state_nxt_s = S_IDLE;
      end
      S_ERR: begin
        if (rd_n_s && wr_n_s) state_nxt_s = S_IDLE;
        else                  state_nxt_s = S_ERR;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Hold counter: loaded on DRIVE entry, counts down while driving
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_r <= 4'd0;
    end else if ((state_nxt_s == S_WR_DRV) || (state_nxt_s == S_RD_DRV)) begin
      if ((state_r == S_WR_CAP) || (state_r == S_RD_CAP)) hold_cnt_r <= HOLD_W'(HOLD_CYCLES);
      else if (hold_cnt_r != 4'd0)                          hold_cnt_r <= hold_cnt_r - 4'd1;
      else                                                  hold_cnt_r <= hold_cnt_r;
    end else begin
      hold_cnt_r <= 4'd0;
    end
  end

  // Registered outputs decoded from the next state so they align with state_r
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Internal_RD_WR <= 1'b0;
      RD_WR          <= 1'b1;
      reg_sel        <= '0;
      reg_we         <= 1'b0;
      reg_oe         <= 1'b0;
      busy           <= 1'b0;
      err            <= 1'b0;
    end else begin
      Internal_RD_WR <= bus_enc_s[1];
      RD_WR          <= bus_enc_s[0];
      reg_we         <= (state_r == S_WR_CAP) && (state_nxt_s == S_WR_DRV);
      reg_oe         <= (state_nxt_s == S_RD_CAP) || (state_nxt_s == S_RD_DRV);
      busy           <= (state_nxt_s != S_IDLE);
      err            <= (state_nxt_s == S_ERR);
      if (state_nxt_s == S_IDLE)               reg_sel <= '0;
      else if ((state_r == S_IDLE) && start_s) reg_sel <= addr_onehot(a_s);
      else                                     reg_sel <= reg_sel;
    end
  end

endmodule

// File: tb/tb_bus_rw_control.sv
// Self-checking bench for bus_rw_control: directed vector table, hand-written
// corner sequences and randomized strobes against a phase-level reference model.
module tb_bus_rw_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n, rd_n, wr_n;
  logic [1:0] a;

  logic       ird_h1, rdwr_h1, we_h1, oe_h1, busy_h1, err_h1;
  logic       ird_h3, rdwr_h3, we_h3, oe_h3, busy_h3, err_h3;
  logic [3:0] sel_h1, sel_h3;
  logic [9:0] out_h1, out_h3;

  int errors = 0;
  int checks = 0;

  localparam logic [9:0] RESET_OUT = 10'b01_0000_0000;

  always #5 clk = ~clk;

  bus_rw_control #(.ADDR_W(2), .HOLD_CYCLES(1)) dut_h1 (
    .clk(clk), .rst(rst), .CS_n(cs_n), .RD_n(rd_n), .WR_n(wr_n), .A(a),
    .Internal_RD_WR(ird_h1), .RD_WR(rdwr_h1), .reg_sel(sel_h1),
    .reg_we(we_h1), .reg_oe(oe_h1), .busy(busy_h1), .err(err_h1)
  );

  bus_rw_control #(.ADDR_W(2), .HOLD_CYCLES(3)) dut_h3 (
    .clk(clk), .rst(rst), .CS_n(cs_n), .RD_n(rd_n), .WR_n(wr_n), .A(a),
    .Internal_RD_WR(ird_h3), .RD_WR(rdwr_h3), .reg_sel(sel_h3),
    .reg_we(we_h3), .reg_oe(oe_h3), .busy(busy_h3), .err(err_h3)
  );

  // Packed view: {Internal_RD_WR, RD_WR, reg_sel[3:0], reg_we, reg_oe, busy, err}
  assign out_h1 = {ird_h1, rdwr_h1, sel_h1, we_h1, oe_h1, busy_h1, err_h1};
  assign out_h3 = {ird_h3, rdwr_h3, sel_h3, we_h3, oe_h3, busy_h3, err_h3};

  // Reference model: bus-cycle phase plus cycles spent driving, per HOLD value
  typedef enum int {P_IDLE, P_WCAP, P_WDRV, P_RCAP, P_RDRV, P_REC, P_ERR} phase_t;
  phase_t     ph[2];
  logic [3:0] msel[2];
  logic       mwe[2];
  int         dc[2];
  int         hv[2] = '{1, 3};

  typedef struct {
    logic       cs, rd, wr;
    logic [1:0] aa;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = P_IDLE; msel[k] = 4'b0; mwe[k] = 1'b0; dc[k] = 0;
    end
  endtask

  function automatic logic [9:0] model_out(input int k);
    logic ird, rdwr, oe;
    ird  = ph[k] inside {P_WCAP, P_WDRV, P_RDRV};
    rdwr = (ph[k] != P_WDRV);
    oe   = ph[k] inside {P_RCAP, P_RDRV};
    return {ird, rdwr, msel[k], mwe[k], oe, ph[k] != P_IDLE, ph[k] == P_ERR};
  endfunction

  task automatic model_step();
    logic conflict, start;
    phase_t nx;
    conflict = !cs_n && !rd_n && !wr_n;
    start    = !cs_n && (rd_n != wr_n);
    for (int k = 0; k < 2; k++) begin
      nx = ph[k];
      case (ph[k])
        P_IDLE: begin
          if (conflict) nx = P_ERR;
          else if (start) begin
            nx = wr_n ? P_RCAP : P_WCAP;
            msel[k] = 4'b0001 << a;
          end
        end
        P_WCAP: nx = conflict ? P_ERR : P_WDRV;
        P_RCAP: nx = conflict ? P_ERR : P_RDRV;
        P_WDRV, P_RDRV: begin
          if (conflict) nx = P_ERR;
          else if (dc[k] >= hv[k] && (cs_n || (ph[k] == P_WDRV ? wr_n : rd_n))) nx = P_REC;
          else dc[k]++;
        end
        P_REC: nx = conflict ? P_ERR : P_IDLE;
        P_ERR: if (rd_n && wr_n) nx = P_IDLE;
        default: nx = P_IDLE;
      endcase
      if ((nx inside {P_WDRV, P_RDRV}) && !(ph[k] inside {P_WDRV, P_RDRV})) dc[k] = 1;
      mwe[k] = (ph[k] == P_WCAP) && (nx == P_WDRV);
      if (nx == P_IDLE) msel[k] = 4'b0;
      ph[k] = nx;
    end
  endtask

  task automatic drive(input logic c, input logic r, input logic w, input logic [1:0] aa);
    cs_n = c; rd_n = r; wr_n = w; a = aa;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("model_h1", out_h1, model_out(0));
    check("model_h3", out_h3, model_out(1));
  endtask

  initial begin
    int drv_cnt;
    int we_cnt;

    // Write A=2 (A changes mid-cycle), read A=1, then a conflict in IDLE
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 2'd2, 10'b11_0100_0010};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd2, 10'b10_0100_1010};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd3, 10'b10_0100_0010};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'd3, 10'b10_0100_0010};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 2'd3, 10'b01_0100_0010};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'd0, 10'b01_0000_0000};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd1, 10'b01_0010_0110};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd1, 10'b11_0010_0110};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'd1, 10'b11_0010_0110};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 2'd1, 10'b01_0010_0010};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 2'd0, 10'b01_0000_0000};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 10'b01_0000_0011};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 2'd0, 10'b01_0000_0011};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 2'd0, 10'b01_0000_0000};

    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 2'd0);
    model_reset();
    #1;
    check("reset_h1", out_h1, RESET_OUT);
    check("reset_h3", out_h3, RESET_OUT);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].cs, tbl[i].rd, tbl[i].wr, tbl[i].aa);
      cycle();
      check($sformatf("vec%0d", i), out_h1, tbl[i].exp);
    end

    // HOLD_CYCLES=3 with a one-cycle write pulse
    drive(1'b1, 1'b1, 1'b1, 2'd0);
    cycle();
    cycle();
    drive(1'b0, 1'b1, 1'b0, 2'd1);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 2'd1);
    drv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (out_h3[9:8] == 2'b10) drv_cnt++;
    end
    check("h3_wr_drv_cycles", drv_cnt, 3);
    check("h3_idle_after", out_h3, RESET_OUT);

    // Strobes toggling while deselected
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, logic'(i % 2), 2'($urandom_range(0, 3)));
      cycle();
      check("cs_high_idle", {out_h1[9:8], out_h1[1]}, 3'b010);
    end

    // Asynchronous reset between edges during WR_DRV
    drive(1'b0, 1'b1, 1'b0, 2'd3);
    cycle();
    cycle();
    check("we_before_rst", out_h1[3], 1'b1);
    #2;
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 2'd0);
    #1;
    check("async_rst_h1", out_h1, RESET_OUT);
    check("async_rst_h3", out_h3, RESET_OUT);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (we_h1 || we_h3) we_cnt++;
    end
    check("no_we_after_rst", we_cnt, 0);

    // Randomized strobes against the model
    for (int i = 0; i < 400; i++) begin
      drive(logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 9) < 6),
            logic'($urandom_range(0, 9) < 6),
            2'($urandom_range(0, 3)));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
